// File: rtl/ps2_jump_receiver.sv
// rtl/ps2_jump_receiver.sv - PS/2 device-to-host frame receiver with jump-key make/break decoder
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_jump_receiver #(
    parameter int         CLK_FREQ_HZ    = 50_000_000,
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = CLK_FREQ_HZ / 5000,
    parameter logic [7:0] JUMP_CODE      = 8'h29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       jump_held,
    output logic       jump_pulse
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tcnt;
    logic          par_ok;
    logic          ext, brk;

    // Sync flops and filter idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            filt   <= 1'b1;
            fcnt   <= '0;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data_in;
            dat_s2 <= dat_s1;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FMAX) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign fall = filt & ~clk_s2 & (fcnt == FMAX);

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    assign par_ok = ^{shreg, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            tcnt       <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tcnt <= '0;
            end else if (tcnt != TMAX) begin
                tcnt <= tcnt + 1'b1;
            end
            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_bit <= dat_s2;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        if (dat_s2 && par_ok) begin
                            scan_code  <= shreg;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tcnt == TMAX) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end

    // E0/F0 are prefixes that qualify the next key byte; E0 29 is a different key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            jump_held  <= 1'b0;
            jump_pulse <= 1'b0;
        end else begin
            jump_pulse <= 1'b0;
            if (scan_valid) begin
                if (scan_code == 8'hE0) begin
                    ext <= 1'b1;
                end else if (scan_code == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (scan_code == JUMP_CODE && !ext) begin
                        if (brk) begin
                            jump_held <= 1'b0;
                        end else begin
                            jump_pulse <= ~jump_held;
                            jump_held  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_jump_receiver.sv
// tb/tb_ps2_jump_receiver.sv - directed table-driven bench for ps2_jump_receiver
module tb_ps2_jump_receiver;

    localparam int H = 42;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err, jump_held, jump_pulse;

    ps2_jump_receiver #(
        .CLK_FREQ_HZ(1_000_000),
        .FILTER_LEN (8),
        .JUMP_CODE  (8'h29)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err),
        .jump_held  (jump_held),
        .jump_pulse (jump_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int sv_cnt = 0, fe_cnt = 0, jp_cnt = 0, both_cnt = 0;
    int sv_cyc = 0, fe_cyc = 0, fall_delta = -1, last_fall_cyc = 0;
    logic held_q = 1'b0;
    int checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (scan_valid) begin sv_cnt++; sv_cyc = cyc; end
            if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
            if (jump_pulse) jp_cnt++;
            if (scan_valid && frame_err) both_cnt++;
            if (held_q && !jump_held) fall_delta = cyc - sv_cyc;
        end
        held_q = jump_held;
    end

    typedef struct {
        logic [7:0] code;
        logic       bad;
        int         sv;
        int         fe;
        int         jp;
        logic       held;
        logic [7:0] scode;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data_in = b;
        idle(H);
        ps2_clk_in = 1'b0;
        last_fall_cyc = cyc;
        idle(H);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] c, input logic bad, input int n);
        logic [10:0] f;
        f = {1'b1, (~^c) ^ bad, c, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        idle(20);
    endtask

    int s0, f0, j0, lat;
    logic prev_held;
    bit seen;

    initial begin
        vecs[0]  = '{8'h29, 1'b0, 1, 0, 1, 1'b1, 8'h29};
        vecs[1]  = '{8'h29, 1'b0, 1, 0, 0, 1'b1, 8'h29};
        vecs[2]  = '{8'h29, 1'b0, 1, 0, 0, 1'b1, 8'h29};
        vecs[3]  = '{8'hF0, 1'b0, 1, 0, 0, 1'b1, 8'hF0};
        vecs[4]  = '{8'h29, 1'b0, 1, 0, 0, 1'b0, 8'h29};
        vecs[5]  = '{8'hE0, 1'b0, 1, 0, 0, 1'b0, 8'hE0};
        vecs[6]  = '{8'h29, 1'b0, 1, 0, 0, 1'b0, 8'h29};
        vecs[7]  = '{8'h12, 1'b0, 1, 0, 0, 1'b0, 8'h12};
`ifdef PS2_PARITY_CHECK_EN
        vecs[8]  = '{8'h29, 1'b1, 0, 1, 0, 1'b0, 8'h12};
        vecs[9]  = '{8'hF0, 1'b0, 1, 0, 0, 1'b0, 8'hF0};
`else
        vecs[8]  = '{8'h29, 1'b1, 1, 0, 1, 1'b1, 8'h29};
        vecs[9]  = '{8'hF0, 1'b0, 1, 0, 0, 1'b1, 8'hF0};
`endif
        vecs[10] = '{8'h29, 1'b0, 1, 0, 0, 1'b0, 8'h29};
        vecs[11] = '{8'hE0, 1'b0, 1, 0, 0, 1'b0, 8'hE0};
        vecs[12] = '{8'h12, 1'b0, 1, 0, 0, 1'b0, 8'h12};
        vecs[13] = '{8'h29, 1'b0, 1, 0, 1, 1'b1, 8'h29};
        vecs[14] = '{8'hF0, 1'b0, 1, 0, 0, 1'b1, 8'hF0};
        vecs[15] = '{8'h29, 1'b0, 1, 0, 0, 1'b0, 8'h29};

        idle(5);
        check("rst_scan_code", int'(scan_code), 0);
        check("rst_scan_valid", int'(scan_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_jump_held", int'(jump_held), 0);
        check("rst_jump_pulse", int'(jump_pulse), 0);
        reset = 1'b1;
        idle(5);

        for (int i = 0; i < 16; i++) begin
            s0 = sv_cnt; f0 = fe_cnt; j0 = jp_cnt; prev_held = jump_held;
            send_bits(vecs[i].code, vecs[i].bad, 11);
            check($sformatf("v%0d_scan_valid_cnt", i), sv_cnt - s0, vecs[i].sv);
            check($sformatf("v%0d_frame_err_cnt", i), fe_cnt - f0, vecs[i].fe);
            check($sformatf("v%0d_jump_pulse_cnt", i), jp_cnt - j0, vecs[i].jp);
            check($sformatf("v%0d_jump_held", i), int'(jump_held), int'(vecs[i].held));
            check($sformatf("v%0d_scan_code", i), int'(scan_code), int'(vecs[i].scode));
            if (prev_held && !vecs[i].held)
                check($sformatf("v%0d_held_fall_delay", i), fall_delta, 1);
        end

        // Clock stops after start + 5 data bits.
        s0 = sv_cnt; f0 = fe_cnt; j0 = jp_cnt;
        send_bits(8'h29, 1'b0, 6);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            idle(1);
            if (fe_cnt != f0) seen = 1'b1;
        end
        check("timeout_seen", int'(seen), 1);
        check("timeout_err_cnt", fe_cnt - f0, 1);
        check("timeout_no_valid", sv_cnt - s0, 0);
        lat = fe_cyc - last_fall_cyc;
        check("timeout_latency_window", int'(lat >= 200 && lat <= 225), 1);
        s0 = sv_cnt;
        send_bits(8'h29, 1'b0, 11);
        check("after_to_valid_cnt", sv_cnt - s0, 1);
        check("after_to_scan_code", int'(scan_code), 8'h29);
        check("after_to_jump_pulse", jp_cnt - j0, 1);
        check("after_to_jump_held", int'(jump_held), 1);

        // Reset mid-frame with clock glitches, then glitches while idle.
        send_bits(8'h12, 1'b0, 4);
        @(negedge clk);
        reset = 1'b0;
        for (int g = 0; g < 3; g++) begin
            ps2_clk_in = 1'b0; idle(3);
            ps2_clk_in = 1'b1; idle(3);
        end
        check("midrst_scan_code", int'(scan_code), 0);
        check("midrst_scan_valid", int'(scan_valid), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_jump_held", int'(jump_held), 0);
        check("midrst_jump_pulse", int'(jump_pulse), 0);
        reset = 1'b1;
        ps2_data_in = 1'b0;
        idle(5);
        s0 = sv_cnt; f0 = fe_cnt; j0 = jp_cnt;
        for (int g = 0; g < 3; g++) begin
            ps2_clk_in = 1'b0; idle(3);
            ps2_clk_in = 1'b1; idle(20);
        end
        idle(300);
        check("glitch_no_err", fe_cnt - f0, 0);
        check("glitch_no_valid", sv_cnt - s0, 0);
        ps2_data_in = 1'b1;
        send_bits(8'h29, 1'b0, 11);
        check("post_rst_valid_cnt", sv_cnt - s0, 1);
        check("post_rst_scan_code", int'(scan_code), 8'h29);
        check("post_rst_jump_pulse", jp_cnt - j0, 1);
        check("post_rst_jump_held", int'(jump_held), 1);
        check("valid_err_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
